// File: rtl/inst_fetch.sv
// inst_fetch: instruction-fetch stage of the 16-bit pipeline. It owns the program counter and a
// direct-mapped, read-only instruction cache, and refills missing lines from main memory one
// word per acknowledged cycle.
//
// Parameters: LINES (cache lines, power of two), WORDS (16-bit words per line, power of two).
// Word address split, LSB first: offset log2(WORDS), index log2(LINES), tag = remaining bits.
//
// Ports:
//   inp_clk, inp_reset_n                 clock, asynchronous active-low reset
//   inp_stall                            hold pc and fetch outputs (ignored during refill)
//   inp_branch_taken, inp_branch_target  redirect request and target pc
//   inp_mem_ack, inp_mem_data            refill word valid for out_mem_addr this cycle
//   out_mem_req, out_mem_addr            refill request (held for the whole line), word address
//   out_hit, out_instruction, out_address  registered fetch result, valid while out_hit = 1
//
// Optional feature: define IFETCH_MISS_CNT_EN to add out_miss_count, a 16-bit wrapping count of
// LOOKUP -> REFILL transitions.
module inst_fetch #(
    parameter int unsigned LINES = 8,
    parameter int unsigned WORDS = 4
) (
    input  logic        inp_clk,
    input  logic        inp_reset_n,
    input  logic        inp_stall,
    input  logic        inp_branch_taken,
    input  logic [15:0] inp_branch_target,
    input  logic        inp_mem_ack,
    input  logic [15:0] inp_mem_data,
    output logic        out_mem_req,
    output logic [15:0] out_mem_addr,
    output logic        out_hit,
    output logic [15:0] out_instruction,
    output logic [15:0] out_address
`ifdef IFETCH_MISS_CNT_EN
    ,
    output logic [15:0] out_miss_count
`endif
);

    localparam int unsigned OffW = $clog2(WORDS);
    localparam int unsigned IdxW = $clog2(LINES);
    localparam int unsigned TagW = 16 - OffW - IdxW;

    typedef enum logic {StLookup, StRefill} state_e;

    state_e             state_q, state_d;
    logic [15:0]        pc_q, pc_d;
    logic               hit_q, hit_d;
    logic [15:0]        instr_q, instr_d;
    logic [15:0]        addr_q, addr_d;
    logic               mem_req_q, mem_req_d;
    logic [15:0]        mem_addr_q, mem_addr_d;
    logic [OffW-1:0]    cnt_q, cnt_d;
    logic               pend_q, pend_d;
    logic [15:0]        pend_tgt_q, pend_tgt_d;
    logic [LINES-1:0]   valid_q, valid_d;

    // Storage arrays need no reset: a line is only read once its valid bit is set.
    logic [15:0]        data_q [LINES*WORDS];
    logic [TagW-1:0]    tag_q  [LINES];

    logic [OffW-1:0]    pc_off;
    logic [IdxW-1:0]    pc_idx;
    logic [TagW-1:0]    pc_tag;
    logic               lookup_hit;
    logic               fill_we;
    logic               tag_we;

    // pc holds during refill, so its index also selects the line being filled.
    assign pc_off     = pc_q[OffW-1:0];
    assign pc_idx     = pc_q[OffW +: IdxW];
    assign pc_tag     = pc_q[15 -: TagW];
    assign lookup_hit = valid_q[pc_idx] && (tag_q[pc_idx] == pc_tag);

    always_comb begin
        state_d    = state_q;
        pc_d       = pc_q;
        hit_d      = hit_q;
        instr_d    = instr_q;
        addr_d     = addr_q;
        mem_req_d  = mem_req_q;
        mem_addr_d = mem_addr_q;
        cnt_d      = cnt_q;
        pend_d     = pend_q;
        pend_tgt_d = pend_tgt_q;
        valid_d    = valid_q;
        fill_we    = 1'b0;
        tag_we     = 1'b0;

        unique case (state_q)
            StLookup: begin
                if (inp_branch_taken) begin
                    pc_d  = inp_branch_target;
                    hit_d = 1'b0;
                end else if (inp_stall) begin
                    // Hold pc and all outputs.
                    hit_d = hit_q;
                end else if (lookup_hit) begin
                    instr_d = data_q[{pc_idx, pc_off}];
                    addr_d  = pc_q;
                    hit_d   = 1'b1;
                    pc_d    = pc_q + 16'd1;
                end else begin
                    hit_d      = 1'b0;
                    mem_req_d  = 1'b1;
                    mem_addr_d = {pc_tag, pc_idx, {OffW{1'b0}}};
                    cnt_d      = '0;
                    state_d    = StRefill;
                end
            end
            StRefill: begin
                // Redirects are deferred until the line completes; the last one wins.
                if (inp_branch_taken) begin
                    pend_d     = 1'b1;
                    pend_tgt_d = inp_branch_target;
                end
                if (inp_mem_ack) begin
                    fill_we = 1'b1;
                    if (cnt_q == OffW'(WORDS - 1)) begin
                        valid_d[pc_idx] = 1'b1;
                        tag_we          = 1'b1;
                        mem_req_d       = 1'b0;
                        state_d         = StLookup;
                        if (pend_d) begin
                            pc_d = pend_tgt_d;
                        end
                        pend_d = 1'b0;
                    end else begin
                        cnt_d      = cnt_q + 1'b1;
                        mem_addr_d = mem_addr_q + 16'd1;
                    end
                end
            end
            default: state_d = StLookup;
        endcase
    end

    always_ff @(posedge inp_clk or negedge inp_reset_n) begin
        if (!inp_reset_n) begin
            state_q    <= StLookup;
            pc_q       <= '0;
            hit_q      <= 1'b0;
            instr_q    <= '0;
            addr_q     <= '0;
            mem_req_q  <= 1'b0;
            mem_addr_q <= '0;
            cnt_q      <= '0;
            pend_q     <= 1'b0;
            pend_tgt_q <= '0;
            valid_q    <= '0;
        end else begin
            state_q    <= state_d;
            pc_q       <= pc_d;
            hit_q      <= hit_d;
            instr_q    <= instr_d;
            addr_q     <= addr_d;
            mem_req_q  <= mem_req_d;
            mem_addr_q <= mem_addr_d;
            cnt_q      <= cnt_d;
            pend_q     <= pend_d;
            pend_tgt_q <= pend_tgt_d;
            valid_q    <= valid_d;
        end
    end

    always_ff @(posedge inp_clk) begin
        if (fill_we) begin
            data_q[{pc_idx, cnt_q}] <= inp_mem_data;
        end
        if (tag_we) begin
            tag_q[pc_idx] <= pc_tag;
        end
    end

    assign out_mem_req     = mem_req_q;
    assign out_mem_addr    = mem_addr_q;
    assign out_hit         = hit_q;
    assign out_instruction = instr_q;
    assign out_address     = addr_q;

`ifdef IFETCH_MISS_CNT_EN
    logic [15:0] miss_cnt_q, miss_cnt_d;

    always_comb begin
        miss_cnt_d = miss_cnt_q;
        if ((state_q == StLookup) && (state_d == StRefill)) begin
            miss_cnt_d = miss_cnt_q + 16'd1;
        end
    end

    always_ff @(posedge inp_clk or negedge inp_reset_n) begin
        if (!inp_reset_n) begin
            miss_cnt_q <= '0;
        end else begin
            miss_cnt_q <= miss_cnt_d;
        end
    end

    assign out_miss_count = miss_cnt_q;
`endif

endmodule
